// File: rtl/usb_rx_nrzi_unstuff_if.sv
// Receive-side bundle: recovered line bit in, framed byte stream out.
// err_count is present only when USB_RX_ERR_CNT_EN is defined.
interface usb_rx_nrzi_unstuff_if;
  logic       data_in;
  logic       rx_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_eop;
  logic       rx_error;
`ifdef USB_RX_ERR_CNT_EN
  logic [7:0] err_count;

  modport slave  (input data_in, output rx_active, rx_data, rx_valid, rx_eop, rx_error, err_count);
  modport master (output data_in, input rx_active, rx_data, rx_valid, rx_eop, rx_error, err_count);
`else
  modport slave  (input data_in, output rx_active, rx_data, rx_valid, rx_eop, rx_error);
  modport master (output data_in, input rx_active, rx_data, rx_valid, rx_eop, rx_error);
`endif
endinterface

// File: rtl/usb_rx_nrzi_unstuff.sv
// HS receive stage: NRZI decode, SYNC hunt, bit-unstuff, LSB-first byte assembly, EOP/error.
// Optional stuff-error counter enabled by defining USB_RX_ERR_CNT_EN.
module usb_rx_nrzi_unstuff #(
  parameter int unsigned SYNC_MIN = 12
) (
  input  logic                 clock_480,
  input  logic                 reset,
  usb_rx_nrzi_unstuff_if.slave bus
);

  typedef enum logic {HUNT, RECV} state_e;

  localparam logic [5:0] SyncMin = 6'(SYNC_MIN);

  state_e     state_q, state_d;
  logic       in_q, in_qq;
  logic [2:0] ones_cnt_q, ones_cnt_d;
  logic [5:0] zero_cnt_q, zero_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_active_q, rx_active_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_eop_q, rx_eop_d;
  logic       rx_error_q, rx_error_d;
  logic       d;

  // No line transition decodes as 1, a transition as 0.
  assign d = ~(in_q ^ in_qq);

  always_ff @(posedge clock_480) begin
    if (reset) begin
      in_q        <= 1'b1;
      in_qq       <= 1'b1;
      state_q     <= HUNT;
      ones_cnt_q  <= '0;
      zero_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_active_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_eop_q    <= 1'b0;
      rx_error_q  <= 1'b0;
    end else begin
      in_q        <= bus.data_in;
      in_qq       <= in_q;
      state_q     <= state_d;
      ones_cnt_q  <= ones_cnt_d;
      zero_cnt_q  <= zero_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_active_q <= rx_active_d;
      rx_valid_q  <= rx_valid_d;
      rx_eop_q    <= rx_eop_d;
      rx_error_q  <= rx_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    zero_cnt_d  = zero_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_active_d = rx_active_q;
    rx_valid_d  = 1'b0;
    rx_eop_d    = 1'b0;
    rx_error_d  = 1'b0;

    if (!d) begin
      ones_cnt_d = '0;
    end else if (ones_cnt_q != 3'd7) begin
      ones_cnt_d = ones_cnt_q + 3'd1;
    end else begin
      ones_cnt_d = ones_cnt_q;
    end

    case (state_q)
      HUNT: begin
        if (!d) begin
          if (zero_cnt_q != 6'd63) zero_cnt_d = zero_cnt_q + 6'd1;
        end else if (zero_cnt_q >= SyncMin) begin
          state_d     = RECV;
          bit_cnt_d   = '0;
          ones_cnt_d  = '0;
          zero_cnt_d  = '0;
          rx_active_d = 1'b1;
        end else begin
          zero_cnt_d = '0;
        end
      end
      RECV: begin
        // A seventh consecutive one is the EOP; it is clean only when 7 bits are pending.
        if (ones_cnt_q == 3'd6 && d) begin
          state_d     = HUNT;
          rx_active_d = 1'b0;
          rx_eop_d    = 1'b1;
          rx_error_d  = (bit_cnt_q != 3'd7);
          zero_cnt_d  = '0;
          bit_cnt_d   = '0;
        end else if (ones_cnt_q != 3'd6) begin
          shreg_d = {d, shreg_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {d, shreg_q[7:1]};
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign bus.rx_active = rx_active_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_eop    = rx_eop_q;
  assign bus.rx_error  = rx_error_q;

`ifdef USB_RX_ERR_CNT_EN
  logic [7:0] err_count_q;

  always_ff @(posedge clock_480) begin
    if (reset) begin
      err_count_q <= '0;
    end else if (rx_error_d && err_count_q != 8'hFF) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign bus.err_count = err_count_q;
`endif

endmodule
